strmblock: RTL and testbench

STRMBLOCK -- requirements
Module: strmblock

---
 rtl/strmblock_pkg.sv | 24 ++
 rtl/strmblock_syncfifo.sv | 59 +++++
 rtl/strmblock.sv | 121 ++++++++++++
 tb/tb_strmblock.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/strmblock_pkg.sv
// Shared stream definitions: block FSM state encoding, stream ids used by the
// message encoder, and the block-size helper.
package strmblock_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        DRAIN = 2'd2
    } blk_state_e;

    localparam logic [3:0] STRM_ID_SAMPLE = 4'd0;
    localparam logic [3:0] STRM_ID_STATUS = 4'd1;
    localparam logic [3:0] STRM_ID_DEBUG  = 4'd2;

    // Words offered in one block: the stored level, capped at the block maximum.
    function automatic logic [7:0] blk_count(input logic [15:0] level,
                                             input logic [7:0]  max_count);
        if (level < {8'd0, max_count}) begin
            return level[7:0];
        end
        return max_count;
    endfunction

endpackage

// File: rtl/strmblock_syncfifo.sv
// Single-clock FIFO: dual-port RAM with asynchronous read of the head word,
// so a word is visible the cycle after it is written or after the prior pop.
module syncfifo #(
    parameter int unsigned ADDR_BITS = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [31:0]          wr_data_i,
    input  logic                 rd_en_i,
    output logic [31:0]          rd_data_o,
    output logic                 full_o,
    output logic [ADDR_BITS:0]   level_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_L = (ADDR_BITS + 1)'(DEPTH);

    logic [31:0]          mem_q [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr_q;
    logic [ADDR_BITS-1:0] rd_ptr_q;
    logic [ADDR_BITS:0]   level_q;
    logic                 wr_ok;
    logic                 rd_ok;

    assign full_o    = (level_q == DEPTH_L);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign wr_ok     = wr_en_i && !full_o;
    assign rd_ok     = rd_en_i && (level_q != '0);

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers are exactly ADDR_BITS wide, so they wrap modulo depth on their own.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + ADDR_BITS'(1);
            end
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + ADDR_BITS'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   level_q <= level_q + (ADDR_BITS + 1)'(1);
                2'b01:   level_q <= level_q - (ADDR_BITS + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/strmblock.sv
// Stream blocker: buffers producer words and offers them to the consumer in
// blocks, triggered by a fill threshold or by an idle timeout.
module strmblock
    import strmblock_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 6,
    parameter int unsigned MAX_COUNT = 60,
    parameter int unsigned THRESHOLD = 16,
    parameter int unsigned TIMEOUT   = 1000,
    parameter logic [3:0]  STRM_ID   = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wr_data,
    input  logic        wr_en,
    output logic        wr_full,
    input  logic        ovf_clear,
    output logic        overflow,
    output logic [31:0] strm_data,
    output logic [7:0]  strm_count,
    output logic [3:0]  strm_id,
    output logic        strm_avail,
    input  logic        strm_pull,
    output logic        proto_err
);

    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]      TIMEOUT_L = TW'(TIMEOUT);
    localparam logic [ADDR_BITS:0] THRESH_L  = (ADDR_BITS + 1)'(THRESHOLD);
    localparam logic [7:0]         MAX_L     = 8'(MAX_COUNT);

    blk_state_e         state_q;
    logic [TW-1:0]      timer_q;
    logic [7:0]         count_q;
    logic [7:0]         remain_q;
    logic               avail_q;
    logic               ovf_q;
    logic               perr_q;
    logic [ADDR_BITS:0] level;
    logic               wr_accept;
    logic               fifo_rd;

    assign wr_accept  = wr_en && !wr_full;
    assign fifo_rd    = strm_pull && (state_q != IDLE);
    assign strm_count = count_q;
    assign strm_avail = avail_q;
    assign strm_id    = STRM_ID;
    assign overflow   = ovf_q;
    assign proto_err  = perr_q;

    syncfifo #(.ADDR_BITS(ADDR_BITS)) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .rd_en_i   (fifo_rd),
        .rd_data_o (strm_data),
        .full_o    (wr_full),
        .level_o   (level)
    );

    // The idle timer restarts on every accepted write, so a partial block is
    // flushed TIMEOUT cycles after the producer goes quiet, not after it starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            count_q  <= '0;
            remain_q <= '0;
            avail_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((level >= THRESH_L) || ((level != '0) && (timer_q == TIMEOUT_L))) begin
                        count_q <= blk_count(16'(level), MAX_L);
                        avail_q <= 1'b1;
                        timer_q <= '0;
                        state_q <= OFFER;
                    end else if ((level == '0) || wr_accept) begin
                        timer_q <= '0;
                    end else if (timer_q != TIMEOUT_L) begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                OFFER: begin
                    if (strm_pull) begin
                        avail_q  <= 1'b0;
                        remain_q <= count_q - 8'd1;
                        state_q  <= (count_q == 8'd1) ? IDLE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (strm_pull) begin
                        remain_q <= remain_q - 8'd1;
                        if (remain_q == 8'd1) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            if (wr_en && wr_full) begin
                ovf_q <= 1'b1;
            end else if (ovf_clear) begin
                ovf_q <= 1'b0;
            end
            if (strm_pull && (state_q == IDLE)) begin
                perr_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_strmblock.sv
// Directed bench for strmblock: a default-threshold instance and a
// full-FIFO instance (threshold 64, timeout 10).
module tb_strmblock;

    localparam int unsigned A_TO = 1000;
    localparam int unsigned B_TO = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic        a_wr_en = 1'b0, a_clr = 1'b0, a_pull = 1'b0;
    logic [31:0] a_wd = '0;
    logic        a_full, a_ovf, a_avail, a_perr;
    logic [31:0] a_data;
    logic [7:0]  a_count;
    logic [3:0]  a_id;

    logic        b_wr_en = 1'b0, b_clr = 1'b0, b_pull = 1'b0;
    logic [31:0] b_wd = '0;
    logic        b_full, b_ovf, b_avail, b_perr;
    logic [31:0] b_data;
    logic [7:0]  b_count;
    logic [3:0]  b_id;

    strmblock #(.ADDR_BITS(6), .MAX_COUNT(60), .THRESHOLD(16), .TIMEOUT(A_TO), .STRM_ID(4'd5)) u_dut (
        .clk(clk), .rst(rst), .wr_data(a_wd), .wr_en(a_wr_en), .wr_full(a_full),
        .ovf_clear(a_clr), .overflow(a_ovf), .strm_data(a_data), .strm_count(a_count),
        .strm_id(a_id), .strm_avail(a_avail), .strm_pull(a_pull), .proto_err(a_perr)
    );

    strmblock #(.ADDR_BITS(6), .MAX_COUNT(60), .THRESHOLD(64), .TIMEOUT(B_TO), .STRM_ID(4'd9)) u_big (
        .clk(clk), .rst(rst), .wr_data(b_wd), .wr_en(b_wr_en), .wr_full(b_full),
        .ovf_clear(b_clr), .overflow(b_ovf), .strm_data(b_data), .strm_count(b_count),
        .strm_id(b_id), .strm_avail(b_avail), .strm_pull(b_pull), .proto_err(b_perr)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: inputs set beforehand are sampled, then cleared 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        a_wr_en = 1'b0; a_clr = 1'b0; a_pull = 1'b0;
        b_wr_en = 1'b0; b_clr = 1'b0; b_pull = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_a(input int maxc, output int n);
        n = 0;
        while (!a_avail && n < maxc) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_b(input int maxc, output int n);
        n = 0;
        while (!b_avail && n < maxc) begin
            tick();
            n++;
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] wd;
        logic        pull;
        logic        avail;
        logic [7:0]  cnt;
        logic        chkd;
        logic [31:0] dat;
        logic        perr;
    } vec_t;

    vec_t tbl[34];

    initial begin
        int n;
        logic [31:0] wd;
        logic [31:0] q[$];

        for (int i = 0; i < 16; i++)
            tbl[i] = '{1'b1, 32'(i + 1), 1'b0, 1'b0, 8'd0, 1'b1, 32'd1, 1'b0};
        tbl[16] = '{1'b0, 32'd0, 1'b0, 1'b1, 8'd16, 1'b1, 32'd1, 1'b0};
        for (int k = 1; k <= 16; k++)
            tbl[16 + k] = '{1'b0, 32'd0, 1'b1, 1'b0, 8'd16, (k < 16), 32'(k + 1), 1'b0};
        tbl[33] = '{1'b0, 32'd0, 1'b1, 1'b0, 8'd16, 1'b0, 32'd0, 1'b1};

        do_reset();
        chk("rst_avail", a_avail, 1'b0);
        chk("rst_count", a_count, 8'd0);
        chk("rst_ovf",   a_ovf,   1'b0);
        chk("rst_perr",  a_perr,  1'b0);
        chk("rst_full",  a_full,  1'b0);
        chk("id_a",      a_id,    4'd5);
        chk("id_b",      b_id,    4'd9);

        // Threshold block of 16, drained in order, then a pull in IDLE.
        for (int i = 0; i < 34; i++) begin
            a_wr_en = tbl[i].wr;
            a_wd    = tbl[i].wd;
            a_pull  = tbl[i].pull;
            tick();
            chk($sformatf("v%0d_avail", i), a_avail, tbl[i].avail);
            chk($sformatf("v%0d_count", i), a_count, tbl[i].cnt);
            if (tbl[i].chkd) chk($sformatf("v%0d_data", i), a_data, tbl[i].dat);
            chk($sformatf("v%0d_perr", i), a_perr, tbl[i].perr);
        end

        // Timeout flush of 3 words; an IDLE pull must not consume anything.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            a_wr_en = 1'b1; a_wd = 32'hA1 + 32'(i);
            tick();
        end
        a_pull = 1'b1;
        tick();
        chk("idle_pull_perr", a_perr, 1'b1);
        chk("idle_pull_head", a_data, 32'hA1);
        wait_a(A_TO + 100, n);
        n = n + 1;
        chk("to_latency_ok", (n >= int'(A_TO) + 1 && n <= int'(A_TO) + 2), 1'b1);
        chk("to_avail", a_avail, 1'b1);
        chk("to_count", a_count, 8'd3);
        for (int k = 0; k < 3; k++) begin
            chk("to_data", a_data, 32'hA1 + 32'(k));
            a_pull = 1'b1;
            tick();
        end
        chk("to_done_avail", a_avail, 1'b0);
        chk("perr_sticky", a_perr, 1'b1);

        // Continuous writes during DRAIN across the pointer wrap.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            a_wr_en = 1'b1; a_wd = 32'(i + 1); q.push_back(32'(i + 1));
            tick();
        end
        for (int r = 0; r < 5; r++) begin
            wait_a(5, n);
            chk($sformatf("wrap_r%0d_avail", r), a_avail, 1'b1);
            chk($sformatf("wrap_r%0d_count", r), a_count, 8'd16);
            for (int j = 0; j < 16; j++) begin
                chk($sformatf("wrap_r%0d_data%0d", r, j), a_data, q.pop_front());
                a_pull = 1'b1;
                if (r < 4) begin
                    wd = 32'h100 * 32'(r + 1) + 32'(j);
                    a_wr_en = 1'b1; a_wd = wd; q.push_back(wd);
                end
                tick();
                chk("wrap_count_hold", a_count, 8'd16);
                chk("wrap_avail_low", a_avail, 1'b0);
            end
        end

        // Full FIFO: blocks of 60 then 4, overflow set/clear.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            b_wr_en = 1'b1; b_wd = 32'h1000 + 32'(i);
            tick();
        end
        chk("full_at_64", b_full, 1'b1);
        chk("no_ovf_yet", b_ovf, 1'b0);
        b_wr_en = 1'b1; b_wd = 32'hDEAD;
        tick();
        chk("ovf_set", b_ovf, 1'b1);
        chk("big_avail", b_avail, 1'b1);
        chk("big_count60", b_count, 8'd60);
        b_wr_en = 1'b1; b_clr = 1'b1;
        tick();
        chk("ovf_set_wins", b_ovf, 1'b1);
        b_clr = 1'b1;
        tick();
        chk("ovf_cleared", b_ovf, 1'b0);
        for (int k = 0; k < 60; k++) begin
            chk("big_data", b_data, 32'h1000 + 32'(k));
            b_pull = 1'b1;
            tick();
            if (k == 0) begin
                chk("big_avail_drop", b_avail, 1'b0);
                chk("big_not_full", b_full, 1'b0);
            end
        end
        wait_b(30, n);
        chk("rem_latency", n, B_TO + 1);
        chk("rem_avail", b_avail, 1'b1);
        chk("rem_count4", b_count, 8'd4);
        for (int k = 0; k < 4; k++) begin
            chk("rem_data", b_data, 32'h103C + 32'(k));
            b_pull = 1'b1;
            tick();
        end
        for (int k = 0; k < 15; k++) tick();
        chk("dropped_word_absent", b_avail, 1'b0);
        chk("big_perr_clean", b_perr, 1'b0);

        // Reset in the middle of a DRAIN abandons the block.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            b_wr_en = 1'b1; b_wd = 32'h2000 + 32'(i);
            tick();
        end
        wait_b(5, n);
        chk("rd_avail", b_avail, 1'b1);
        b_pull = 1'b1; tick();
        b_pull = 1'b1; tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rd_rst_avail", b_avail, 1'b0);
        chk("rd_rst_full", b_full, 1'b0);
        chk("rd_rst_count", b_count, 8'd0);
        for (int k = 0; k < 25; k++) tick();
        chk("rd_level_zero", b_avail, 1'b0);
        b_wr_en = 1'b1; b_wd = 32'h3000;
        tick();
        chk("rd_new_head", b_data, 32'h3000);
        wait_b(30, n);
        chk("rd_new_avail", b_avail, 1'b1);
        chk("rd_new_count", b_count, 8'd1);
        b_pull = 1'b1;
        tick();
        chk("rd_single_done", b_avail, 1'b0);
        chk("rd_perr", b_perr, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
